parzen_window_arbiter: RTL
==========================

# parzen_window_arbiter

Shares one Parzen window coefficient generator between two consumer channels. Each grant covers one complete window frame. The arbiter sits between the generator's AXI-stream-style output (data/valid/ready/last) and two downstream consumers, such as per-channel windowing multipliers. It grants whole frames in round-robin order and routes the coefficient stream and backpressure to the granted channel only.

## Interface
Parameters:
- `WINDOW_SIZE_POW2`, default 10: log2 of the frame length N; must match the generator.
- `OUTPUT_INT`, default 1: integer bits of the coefficient.
- `OUTPUT_FRAC`, default 16: fractional bits of the coefficient.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset. It is shared with the generator.
- `req` in 2: per-channel frame request (level). Bit i belongs to channel i.
- `gnt` out 2: one-hot registered grant, or all zeros.
- `gen_ready` out 1: ready to the generator.
- `gen_data` in `[OUTPUT_INT-1:-OUTPUT_FRAC]`: generator coefficient.
- `gen_valid` in 1: generator valid.
- `gen_last` in 1: generator last beat of the frame.
- `ch0_data`, `ch1_data` out `[OUTPUT_INT-1:-OUTPUT_FRAC]`: routed coefficient.
- `ch0_valid`, `ch1_valid` out 1: routed valid.
- `ch0_last`, `ch1_last` out 1: routed last.
- `ch0_ready`, `ch1_ready` in 1: consumer ready.
- `sync_err` out 1: sticky flag, set when a frame-length mismatch is detected.

## Operation
- A beat is accepted when `gen_valid & gen_ready` is high.
- FSM states: IDLE and BUSY. There is also a 1-bit `last_served` pointer.
- IDLE:
  - `gnt` = 0 and `gen_ready` = 0.
  - If any `req` bit is high, grant the requesting channel. If both request, grant the channel that is not `last_served`.
  - `gnt` is registered and the FSM moves to BUSY.
- BUSY:
  - `gen_ready` = `chK_ready` of the granted channel K.
  - `chK_valid` = `gen_valid`, `chK_last` = `gen_last`, `chK_data` = `gen_data`.
  - The non-granted channel sees valid = 0, last = 0, data = 0.
- Leaving BUSY: when a beat is accepted with `gen_last` high:
  - `last_served` <= K, `gnt` <= 0, FSM moves to IDLE.
  - This inserts one idle cycle between frames.
- `req` is sampled only in IDLE. Dropping `req` during BUSY does not shorten the frame; the frame always runs to `gen_last`.
- No beat is consumed outside BUSY, so the generator stalls and frame alignment is preserved.
- Because `rst` is shared with the generator, frame 0 starts at the first beat after reset.
- Reset mid-frame discards the frame. The generator restarts in step, so alignment is restored.
- Non-granted data outputs are forced to 0 and are never X.

## Timing
- Reset values:
  - `gnt` = 2'b00, `gen_ready` = 0.
  - All `chX_valid`, `chX_last`, `chX_data` = 0.
  - `sync_err` = 0.
  - FSM = IDLE, `last_served` = 1 (channel 0 wins first), beat counter = 0.
- `req` high in cycle t (FSM in IDLE) gives `gnt` high in cycle t+1.
- Data path latency is 0 cycles: the routing is combinational on the registered `gnt`.
- `gen_ready` is combinational from `chK_ready`. There is no skid buffer.
- Frame-to-frame gap is exactly 1 cycle: the IDLE cycle after last accept.
- Simultaneous requests alternate: 0, 1, 0, 1, and so on.
- A single persistent requester is re-granted every frame, with the 1-cycle gap.

## Configuration
- Macro `PARZEN_ARB_FRAME_CHECK_EN`.
- When defined:
  - A `WINDOW_SIZE_POW2`-bit beat counter increments on each accepted beat in BUSY.
  - It clears to 0 on an accepted last beat.
  - `sync_err` sets, sticky until `rst`, if an accepted beat has `gen_last` = 1 while count ≠ N-1.
  - It also sets if an accepted beat has `gen_last` = 0 while count = N-1.
- When not defined: no counter is built and `sync_err` is tied to 0.

## Test plan
Bench uses `WINDOW_SIZE_POW2`=3 (N=8) and a real generator instance unless stated otherwise.

1. **Reset:** hold `rst` for 3 cycles → all outputs 0. Release with `req`=2'b00 for 20 cycles → `gen_ready` stays 0 and no `chX_valid`.
2. **Single channel:** `req`=2'b01 constantly, `ch0_ready`=1 → `gnt`=01 one cycle after `req`. `ch0` receives 8 beats with `ch0_last` on beat 8, then one cycle with `gnt`=00, then the next frame. `ch1_valid` stays 0 throughout.
3. **Contention:** `req`=2'b11 from reset, both readies=1 → frames granted in the order ch0, ch1, ch0, ch1. Each frame is 8 beats and the coefficient sequences are identical across frames.
4. **Backpressure:** ch0 granted, `ch0_ready` toggles 1/0 each cycle → `gen_ready` mirrors it. The frame completes in about 16 cycles with 8 accepted beats, no beat duplicated or lost.
5. **Request drop and reset mid-frame:**
   - Drop `req`[0] after beat 3 → the frame still completes all 8 beats.
   - Assert `rst` at beat 5 of a ch1 frame → next cycle `gnt`=00. The following grant goes to ch0 and starts at beat 1 of the window.
6. **Frame check (with `PARZEN_ARB_FRAME_CHECK_EN`), using a stub generator:**
   - Drive `gen_last` on beat 6 → `sync_err` rises the cycle after that beat and stays 1 until `rst`.
   - Without the macro, the same stimulus → `sync_err` stays 0.

Source files
------------

// File: rtl/parzen_window_arbiter.sv
// Round-robin frame arbiter sharing one Parzen window generator between two consumers.
// Optional frame-length checker enabled by defining PARZEN_ARB_FRAME_CHECK_EN.
module parzen_window_arbiter #(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int OUTPUT_INT       = 1,
  parameter int OUTPUT_FRAC      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      req,
  output logic [1:0]                      gnt,
  output logic                            gen_ready,
  input  logic [OUTPUT_INT-1:-OUTPUT_FRAC] gen_data,
  input  logic                            gen_valid,
  input  logic                            gen_last,
  output logic [OUTPUT_INT-1:-OUTPUT_FRAC] ch0_data,
  output logic                            ch0_valid,
  output logic                            ch0_last,
  input  logic                            ch0_ready,
  output logic [OUTPUT_INT-1:-OUTPUT_FRAC] ch1_data,
  output logic                            ch1_valid,
  output logic                            ch1_last,
  input  logic                            ch1_ready,
  output logic                            sync_err
);

  // Handshake: a beat transfers on a cycle where gen_valid & gen_ready are both high;
  // gen_ready is the granted consumer's ready, so each beat is seen exactly once downstream.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  logic   last_served;
  logic   accept;

  // gnt is zero in IDLE, so routing and ready collapse to zero there without a state term.
  always_comb begin
    gen_ready = (gnt[0] & ch0_ready) | (gnt[1] & ch1_ready);
    accept    = gen_valid & gen_ready;
    ch0_valid = gnt[0] & gen_valid;
    ch0_last  = gnt[0] & gen_last;
    ch0_data  = gnt[0] ? gen_data : '0;
    ch1_valid = gnt[1] & gen_valid;
    ch1_last  = gnt[1] & gen_last;
    ch1_data  = gnt[1] ? gen_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= BUSY;
            if (req == 2'b11) gnt <= last_served ? 2'b01 : 2'b10;
            else              gnt <= req;
          end
        end
        BUSY: begin
          if (accept && gen_last) begin
            last_served <= gnt[1];
            gnt         <= 2'b00;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

`ifdef PARZEN_ARB_FRAME_CHECK_EN
  localparam logic [WINDOW_SIZE_POW2-1:0] LAST_IDX = {WINDOW_SIZE_POW2{1'b1}};

  logic [WINDOW_SIZE_POW2-1:0] beat_cnt;

  // A last beat must land exactly on index N-1, and index N-1 must carry last.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      sync_err <= 1'b0;
    end else if (state == BUSY && accept) begin
      if (gen_last) begin
        beat_cnt <= '0;
        if (beat_cnt != LAST_IDX) sync_err <= 1'b1;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == LAST_IDX) sync_err <= 1'b1;
      end
    end
  end
`else
  assign sync_err = 1'b0;
`endif

endmodule
